// File: rtl/lcd_bus_arbiter.sv
// Shares an HD44780-style 8-bit LCD bus between two write requesters.
// Runs the power-up init sequence, then serves writes round-robin.
module lcd_bus_arbiter #(
    parameter int POWERUP_CYC = 1000,
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 4,
    parameter int HOLD_CYC    = 2,
    parameter int EXEC_CYC    = 50,
    parameter int LONG_CYC    = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       init_done,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    typedef enum logic [2:0] {
        INIT_WAIT,
        SETUP,
        PULSE,
        HOLD,
        EXEC,
        IDLE
    } state_t;

    localparam logic [15:0] POW_END = 16'(POWERUP_CYC - 1);
    localparam logic [15:0] SET_END = 16'(SETUP_CYC - 1);
    localparam logic [15:0] PUL_END = 16'(PULSE_CYC - 1);
    localparam logic [15:0] HLD_END = 16'(HOLD_CYC - 1);
    localparam logic [15:0] EXE_END = 16'(EXEC_CYC - 1);
    localparam logic [15:0] LNG_END = 16'(LONG_CYC - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  idx, idx_n;
    logic        rs_q, rs_n;
    logic [7:0]  data_q, data_n;
    logic        pref, pref_n;
    logic        done_n;
    logic        ack0_n, ack1_n;
    logic        is_long;
    logic        g0, g1;
    logic [15:0] exec_end;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] c;
        unique case (i)
            2'd0: c = 8'h3C;
            2'd1: c = 8'h0C;
            2'd2: c = 8'h06;
            default: c = 8'h01;
        endcase
        return c;
    endfunction

    // clear and return-home need the long execute wait
    assign is_long  = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign exec_end = is_long ? LNG_END : EXE_END;

    // pref=1 means requester 1 wins a tie
    assign g1 = req1 && (!req0 || pref);
    assign g0 = req0 && !g1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        idx_n   = idx;
        rs_n    = rs_q;
        data_n  = data_q;
        pref_n  = pref;
        done_n  = init_done;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        unique case (state)
            INIT_WAIT: begin
                if (cnt == POW_END) begin
                    state_n = SETUP;
                    cnt_n   = 16'd0;
                    idx_n   = 2'd0;
                    rs_n    = 1'b0;
                    data_n  = init_cmd(2'd0);
                end
            end
            SETUP: begin
                if (cnt == SET_END) begin
                    state_n = PULSE;
                    cnt_n   = 16'd0;
                end
            end
            PULSE: begin
                if (cnt == PUL_END) begin
                    state_n = HOLD;
                    cnt_n   = 16'd0;
                end
            end
            HOLD: begin
                if (cnt == HLD_END) begin
                    state_n = EXEC;
                    cnt_n   = 16'd0;
                end
            end
            EXEC: begin
                if (cnt == exec_end) begin
                    cnt_n = 16'd0;
                    if (!init_done && idx != 2'd3) begin
                        state_n = SETUP;
                        idx_n   = idx + 2'd1;
                        rs_n    = 1'b0;
                        data_n  = init_cmd(idx + 2'd1);
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            IDLE: begin
                cnt_n = 16'd0;
                if (g0) begin
                    state_n = SETUP;
                    rs_n    = rs0;
                    data_n  = data0;
                    ack0_n  = 1'b1;
                    pref_n  = 1'b1;
                end else if (g1) begin
                    state_n = SETUP;
                    rs_n    = rs1;
                    data_n  = data1;
                    ack1_n  = 1'b1;
                    pref_n  = 1'b0;
                end
            end
            default: begin
                state_n = INIT_WAIT;
                cnt_n   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT_WAIT;
            cnt       <= 16'd0;
            idx       <= 2'd0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            pref      <= 1'b0;
            init_done <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            rs_q      <= rs_n;
            data_q    <= data_n;
            pref      <= pref_n;
            init_done <= done_n;
            ack0      <= ack0_n;
            ack1      <= ack1_n;
        end
    end

    assign busy     = (state != IDLE);
    assign lcd_e    = (state == PULSE);
    assign lcd_rw   = !(state == SETUP || state == PULSE || state == HOLD);
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: a waveform-queue model checked every cycle,
// plus hand-computed expectations on pulses, grants and durations.
module tb_lcd_bus_arbiter;

    localparam int P_POW  = 4;
    localparam int P_SET  = 2;
    localparam int P_PUL  = 4;
    localparam int P_HLD  = 2;
    localparam int P_EXE  = 5;
    localparam int P_LNG  = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, rs0 = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       req1 = 1'b0, rs1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       ack0, ack1, init_done, busy;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    lcd_bus_arbiter #(
        .POWERUP_CYC(P_POW), .SETUP_CYC(P_SET), .PULSE_CYC(P_PUL),
        .HOLD_CYC(P_HLD), .EXEC_CYC(P_EXE), .LONG_CYC(P_LNG)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
        .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
        .init_done(init_done), .busy(busy),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       e;
        logic       rs;
        logic       rw;
        logic [7:0] data;
        logic       busy;
        logic       a0;
        logic       a1;
        logic       idn;
    } ent_t;

    // expected bus waveform, one entry per clock cycle
    ent_t       q[$];
    ent_t       cur;
    logic       last_rs;
    logic [7:0] last_data;
    logic       pref;
    logic       init_m;

    int checks = 0;
    int errors = 0;

    logic [8:0] pulse_q[$];
    int         len_q[$];
    int         plen = 0;
    logic       prev_e = 1'b0;
    int         low_run = 0;
    int         ack_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_txn(input logic r, input logic [7:0] d,
                            input logic a0, input logic a1);
        int nexec;
        nexec = (!r && d >= 8'h01 && d <= 8'h03) ? P_LNG : P_EXE;
        for (int i = 0; i < P_SET; i++)
            q.push_back('{e:1'b0, rs:r, rw:1'b0, data:d, busy:1'b1,
                          a0:(i == 0) && a0, a1:(i == 0) && a1,
                          idn:init_m});
        for (int i = 0; i < P_PUL; i++)
            q.push_back('{e:1'b1, rs:r, rw:1'b0, data:d, busy:1'b1,
                          a0:1'b0, a1:1'b0, idn:init_m});
        for (int i = 0; i < P_HLD; i++)
            q.push_back('{e:1'b0, rs:r, rw:1'b0, data:d, busy:1'b1,
                          a0:1'b0, a1:1'b0, idn:init_m});
        for (int i = 0; i < nexec; i++)
            q.push_back('{e:1'b0, rs:r, rw:1'b1, data:d, busy:1'b1,
                          a0:1'b0, a1:1'b0, idn:init_m});
        last_rs   = r;
        last_data = d;
    endtask

    task automatic model_reset();
        ent_t w;
        q.delete();
        last_rs   = 1'b0;
        last_data = 8'h00;
        pref      = 1'b0;
        init_m    = 1'b0;
        w = '{e:1'b0, rs:1'b0, rw:1'b1, data:8'h00, busy:1'b1,
              a0:1'b0, a1:1'b0, idn:1'b0};
        cur = w;
        for (int i = 0; i < P_POW - 1; i++) q.push_back(w);
        push_txn(1'b0, 8'h3C, 1'b0, 1'b0);
        push_txn(1'b0, 8'h0C, 1'b0, 1'b0);
        push_txn(1'b0, 8'h06, 1'b0, 1'b0);
        push_txn(1'b0, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic model_step();
        logic w1;
        if (!rst) begin
            model_reset();
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (!cur.busy && (req0 || req1)) begin
            w1 = req1 && (!req0 || pref);
            pref = !w1;
            if (w1) push_txn(rs1, data1, 1'b0, 1'b1);
            else    push_txn(rs0, data0, 1'b1, 1'b0);
            cur = q.pop_front();
        end else begin
            init_m = 1'b1;
            cur = '{e:1'b0, rs:last_rs, rw:1'b1, data:last_data,
                    busy:1'b0, a0:1'b0, a1:1'b0, idn:1'b1};
        end
    endtask

    task automatic compare();
        chk("lcd_e",     32'(lcd_e),     32'(cur.e));
        chk("lcd_rs",    32'(lcd_rs),    32'(cur.rs));
        chk("lcd_rw",    32'(lcd_rw),    32'(cur.rw));
        chk("lcd_data",  32'(lcd_data),  32'(cur.data));
        chk("busy",      32'(busy),      32'(cur.busy));
        chk("ack0",      32'(ack0),      32'(cur.a0));
        chk("ack1",      32'(ack1),      32'(cur.a1));
        chk("init_done", 32'(init_done), 32'(cur.idn));
    endtask

    task automatic monitor();
        if (lcd_e && !prev_e) begin
            pulse_q.push_back({lcd_rs, lcd_data});
            plen = 0;
        end
        if (lcd_e) plen++;
        else if (prev_e) len_q.push_back(plen);
        if (lcd_e) low_run = 0;
        else low_run++;
        ack_cnt += int'(ack0) + int'(ack1);
        prev_e = lcd_e;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        monitor();
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 500) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 32'(init_done), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic id, input logic r,
                            input logic [7:0] d, output int blen);
        logic got = 1'b0;
        if (id) begin req1 = 1'b1; rs1 = r; data1 = d; end
        else    begin req0 = 1'b1; rs0 = r; data0 = d; end
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            got = id ? ack1 : ack0;
        end
        chk("ack_timeout", 32'(got), 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        blen = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy) break;
            blen++;
        end
    endtask

    initial begin
        int blen;
        int order[4];
        int n;
        int idle_seen;
        logic got;

        model_reset();
        tick();
        tick();
        chk("rst_rw", 32'(lcd_rw), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        pulse_q.delete();
        len_q.delete();
        ack_cnt = 0;
        wait_init("init");
        chk("init_pulses", 32'(pulse_q.size()), 32'd4);
        if (pulse_q.size() == 4) begin
            chk("init_cmd0", 32'(pulse_q[0]), 32'h03C);
            chk("init_cmd1", 32'(pulse_q[1]), 32'h00C);
            chk("init_cmd2", 32'(pulse_q[2]), 32'h006);
            chk("init_cmd3", 32'(pulse_q[3]), 32'h001);
        end
        foreach (len_q[i]) chk("init_pulse_len", 32'(len_q[i]), 32'd4);
        chk("init_gap", 32'(low_run), 32'd23);
        chk("init_no_ack", 32'(ack_cnt), 32'd0);

        pulse_q.delete();
        len_q.delete();
        do_write(1'b1, 1'b1, 8'h48, blen);
        chk("single_busy_len", 32'(blen), 32'd13);
        chk("single_pulse", 32'(pulse_q[0]), 32'h148);
        chk("single_pulse_len", 32'(len_q[0]), 32'd4);

        pulse_q.delete();
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h42;
        n = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            tick();
            if (ack0) begin order[n] = 0; n++; end
            else if (ack1) begin order[n] = 1; n++; end
            if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("rr_count", 32'(n), 32'd4);
        chk("rr_0", 32'(order[0]), 32'd0);
        chk("rr_1", 32'(order[1]), 32'd1);
        chk("rr_2", 32'(order[2]), 32'd0);
        chk("rr_3", 32'(order[3]), 32'd1);
        wait_idle();
        chk("rr_pulses", 32'(pulse_q.size()), 32'd4);
        if (pulse_q.size() == 4) begin
            chk("rr_data0", 32'(pulse_q[0]), 32'h141);
            chk("rr_data1", 32'(pulse_q[1]), 32'h142);
        end

        do_write(1'b0, 1'b0, 8'h01, blen);
        chk("long_busy_len", 32'(blen), 32'd28);
        do_write(1'b0, 1'b0, 8'h80, blen);
        chk("short_busy_len", 32'(blen), 32'd13);
        do_write(1'b1, 1'b0, 8'h02, blen);
        chk("home_busy_len", 32'(blen), 32'd28);

        pulse_q.delete();
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h55;
        tick();
        chk("busy_ack1", 32'(ack1), 32'd1);
        req1 = 1'b0;
        data1 = 8'hAA;
        for (int i = 0; i < 20 && !lcd_e; i++) tick();
        tick();
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h5A;
        idle_seen = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (!busy) idle_seen++;
            got = ack0;
        end
        chk("pend_ack0", 32'(got), 32'd1);
        req0 = 1'b0;
        data0 = 8'hFF;
        chk("pend_idle_cycles", 32'(idle_seen), 32'd1);
        wait_idle();
        chk("pend_pulses", 32'(pulse_q.size()), 32'd2);
        if (pulse_q.size() == 2) begin
            chk("pend_data1", 32'(pulse_q[0]), 32'h155);
            chk("pend_data0", 32'(pulse_q[1]), 32'h15A);
        end

        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h33;
        tick();
        req1 = 1'b0;
        for (int i = 0; i < 20 && !lcd_e; i++) tick();
        tick();
        chk("pre_rst_e", 32'(lcd_e), 32'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst_e", 32'(lcd_e), 32'd0);
        chk("arst_rw", 32'(lcd_rw), 32'd1);
        chk("arst_data", 32'(lcd_data), 32'd0);
        chk("arst_done", 32'(init_done), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        pulse_q.delete();
        wait_init("reinit");
        chk("reinit_pulses", 32'(pulse_q.size()), 32'd4);
        if (pulse_q.size() == 4) begin
            chk("reinit_cmd0", 32'(pulse_q[0]), 32'h03C);
            chk("reinit_cmd3", 32'(pulse_q[3]), 32'h001);
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
